prescaled_event_counter: RTL and testbench

Parametrised multi-channel prescaled counter bank: the next generation of the PLL test counters. Each of NUM_CH channels counts qualified event cycles through a shared, runtime-programmable prescaler. Channels have per-channel enable and clear, wrap or saturate mode, sticky overflow flags, and an atomic all-channel snapshot. All channels run in one clock domain; event sources from other domains are synchronised to clk_0 upstream of this block.

---
 rtl/prescaled_event_counter_pkg.sv | 16 +
 rtl/prescaled_counter_ch.sv | 68 ++++++
 rtl/prescaled_event_counter.sv | 70 +++++++
 tb/tb_prescaled_event_counter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_event_counter_pkg.sv
// Shared definitions for the prescaled event counter bank: default divide,
// overflow mode encodings and the effective-divide helper.
package prescaled_event_counter_pkg;

    localparam int unsigned DEFAULT_DIV = 10000;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // A divide value of zero is treated as divide-by-one so the prescaler
    // compare never needs to handle an underflowed terminal value.
    function automatic logic [31:0] div_eff_f(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/prescaled_counter_ch.sv
// One counter channel: prescaler, event counter and sticky overflow flag.
// Clear outranks any tick in the same cycle; enable low freezes all state.
module prescaled_counter_ch
    import prescaled_event_counter_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 21
) (
    input  logic               clk_0,
    input  logic               i_reg_rstn,
    input  logic               i_en,
    input  logic               i_evt,
    input  logic               i_clr,
    input  logic               i_sat_mode,
    input  logic [PRESC_W-1:0] i_div_eff,
    output logic [CNT_W-1:0]   o_counter,
    output logic               o_ovf
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic qual;
    assign qual = i_en & i_evt & ~i_clr;

    // Next-state: clear, else prescale qualified cycles and tick the counter
    // at terminal count (>= so a lowered divide ticks on the next qualified cycle).
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (i_clr) begin
            presc_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (qual) begin
            if (presc_q >= (i_div_eff - PRESC_W'(1))) begin
                presc_d = '0;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    ovf_d = 1'b1;
                    cnt_d = (i_sat_mode == MODE_SAT) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_0) begin
        if (!i_reg_rstn) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_counter = cnt_q;
    assign o_ovf     = ovf_q;

endmodule

// File: rtl/prescaled_event_counter.sv
// Multi-channel prescaled event counter bank with a shared runtime divide
// and an atomic snapshot of all live counters.
module prescaled_event_counter
    import prescaled_event_counter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 21
) (
    input  logic                    clk_0,
    input  logic                    i_reg_rstn,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH-1:0]       i_evt,
    input  logic [PRESC_W-1:0]      i_div,
    input  logic                    i_sat_mode,
    input  logic [NUM_CH-1:0]       i_clr,
    input  logic                    i_snap,
    output logic [NUM_CH*CNT_W-1:0] o_counter,
    output logic [NUM_CH*CNT_W-1:0] o_snap,
    output logic                    o_snap_vld,
    output logic [NUM_CH-1:0]       o_ovf
);

    logic [PRESC_W-1:0] div_eff;
    assign div_eff = PRESC_W'(div_eff_f(32'(i_div)));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        prescaled_counter_ch #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk_0      (clk_0),
            .i_reg_rstn (i_reg_rstn),
            .i_en       (i_en[k]),
            .i_evt      (i_evt[k]),
            .i_clr      (i_clr[k]),
            .i_sat_mode (i_sat_mode),
            .i_div_eff  (div_eff),
            .o_counter  (o_counter[k*CNT_W +: CNT_W]),
            .o_ovf      (o_ovf[k])
        );
    end

    logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;
    logic                    snap_vld_q, snap_vld_d;

    // Snapshot captures the registered (pre-update, pre-clear) counters.
    always_comb begin
        snap_d     = snap_q;
        snap_vld_d = i_snap;
        if (i_snap) begin
            snap_d = o_counter;
        end
    end

    // Snapshot registers with synchronous active-low reset.
    always_ff @(posedge clk_0) begin
        if (!i_reg_rstn) begin
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    assign o_snap     = snap_q;
    assign o_snap_vld = snap_vld_q;

endmodule

// File: tb/tb_prescaled_event_counter.sv
module tb_prescaled_event_counter;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 21;

    logic                    clk_0;
    logic                    i_reg_rstn;
    logic [NUM_CH-1:0]       i_en;
    logic [NUM_CH-1:0]       i_evt;
    logic [PRESC_W-1:0]      i_div;
    logic                    i_sat_mode;
    logic [NUM_CH-1:0]       i_clr;
    logic                    i_snap;
    logic [NUM_CH*CNT_W-1:0] o_counter;
    logic [NUM_CH*CNT_W-1:0] o_snap;
    logic                    o_snap_vld;
    logic [NUM_CH-1:0]       o_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    prescaled_event_counter #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk_0      (clk_0),
        .i_reg_rstn (i_reg_rstn),
        .i_en       (i_en),
        .i_evt      (i_evt),
        .i_div      (i_div),
        .i_sat_mode (i_sat_mode),
        .i_clr      (i_clr),
        .i_snap     (i_snap),
        .o_counter  (o_counter),
        .o_snap     (o_snap),
        .o_snap_vld (o_snap_vld),
        .o_ovf      (o_ovf)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    task automatic step(input int n);
        repeat (n) @(posedge clk_0);
        #1;
    endtask

    task automatic apply_reset();
        i_en = '0; i_evt = '0; i_div = '0; i_sat_mode = 1'b0;
        i_clr = '0; i_snap = 1'b0;
        i_reg_rstn = 1'b0;
        step(1);
        i_reg_rstn = 1'b1;
    endtask

    task automatic test_reset();
        i_reg_rstn = 1'b1;
        i_en = 2'b11; i_evt = 2'b11; i_div = '0; i_snap = 1'b1;
        i_clr = '0; i_sat_mode = 1'b0;
        step(5);
        i_en = 2'($urandom); i_evt = 2'($urandom); i_div = PRESC_W'($urandom_range(0, 7));
        i_snap = 1'b1;
        i_reg_rstn = 1'b0;
        step(1);
        tests_run++;
        if (o_counter !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_counter: got %h want %h", o_counter, 16'h0000);
        end
        tests_run++;
        if ({o_snap, o_snap_vld, o_ovf} !== 19'h0) begin
            tests_failed++; $display("FAIL reset_snap_ovf: got %h want %h", {o_snap, o_snap_vld, o_ovf}, 19'h0);
        end
        i_reg_rstn = 1'b1; i_en = '0; i_snap = 1'b0;
        step(4);
        tests_run++;
        if ({o_counter, o_snap, o_snap_vld, o_ovf} !== 35'h0) begin
            tests_failed++; $display("FAIL reset_idle: got %h want %h", {o_counter, o_snap, o_snap_vld, o_ovf}, 35'h0);
        end
    endtask

    task automatic test_divide();
        apply_reset();
        i_div = 21'd4; i_en = 2'b11; i_evt = 2'b11;
        step(3);
        tests_run++;
        if (o_counter !== 16'h0000) begin
            tests_failed++; $display("FAIL div4_before_first: got %h want %h", o_counter, 16'h0000);
        end
        step(1);
        tests_run++;
        if (o_counter !== {8'd1, 8'd1}) begin
            tests_failed++; $display("FAIL div4_first: got %h want %h", o_counter, {8'd1, 8'd1});
        end
        step(36);
        tests_run++;
        if (o_counter !== {8'd10, 8'd10}) begin
            tests_failed++; $display("FAIL div4_40cyc: got %h want %h", o_counter, {8'd10, 8'd10});
        end
        i_div = 21'd0;
        step(1);
        tests_run++;
        if (o_counter !== {8'd11, 8'd11}) begin
            tests_failed++; $display("FAIL div0_first: got %h want %h", o_counter, {8'd11, 8'd11});
        end
        step(5);
        tests_run++;
        if (o_counter !== {8'd16, 8'd16}) begin
            tests_failed++; $display("FAIL div0_every: got %h want %h", o_counter, {8'd16, 8'd16});
        end
    endtask

    task automatic test_gating();
        apply_reset();
        i_div = 21'd2; i_en = 2'b11; i_evt = 2'b11;
        step(1);                       // both prescalers now at 1
        i_en = 2'b01;
        for (int i = 0; i < 16; i++) begin
            i_evt = {1'b1, ~i[0]};
            step(1);
        end
        tests_run++;
        if (o_counter !== {8'd0, 8'd4}) begin
            tests_failed++; $display("FAIL gating_counts: got %h want %h", o_counter, {8'd0, 8'd4});
        end
        i_en = 2'b10; i_evt = 2'b11;
        step(1);                       // frozen ch1 prescaler ticks immediately
        tests_run++;
        if (o_counter !== {8'd1, 8'd4}) begin
            tests_failed++; $display("FAIL gating_frozen_presc: got %h want %h", o_counter, {8'd1, 8'd4});
        end
    endtask

    task automatic test_wrap_sat();
        apply_reset();
        i_div = 21'd1; i_sat_mode = 1'b0; i_en = 2'b01; i_evt = 2'b01;
        step(254);
        tests_run++;
        if (o_counter[7:0] !== 8'd254) begin
            tests_failed++; $display("FAIL wrap_preload: got %0d want %0d", o_counter[7:0], 254);
        end
        step(1);
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd255, 2'b00}) begin
            tests_failed++; $display("FAIL wrap_255: got %h want %h", {o_counter[7:0], o_ovf}, {8'd255, 2'b00});
        end
        step(1);
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd0, 2'b01}) begin
            tests_failed++; $display("FAIL wrap_zero_ovf: got %h want %h", {o_counter[7:0], o_ovf}, {8'd0, 2'b01});
        end
        i_clr = 2'b01;
        step(1);
        i_clr = 2'b00;
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd0, 2'b00}) begin
            tests_failed++; $display("FAIL wrap_clear: got %h want %h", {o_counter[7:0], o_ovf}, {8'd0, 2'b00});
        end

        apply_reset();
        i_div = 21'd1; i_sat_mode = 1'b1; i_en = 2'b01; i_evt = 2'b01;
        step(255);
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd255, 2'b00}) begin
            tests_failed++; $display("FAIL sat_255: got %h want %h", {o_counter[7:0], o_ovf}, {8'd255, 2'b00});
        end
        step(2);
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd255, 2'b01}) begin
            tests_failed++; $display("FAIL sat_hold_ovf: got %h want %h", {o_counter[7:0], o_ovf}, {8'd255, 2'b01});
        end
        i_clr = 2'b01;
        step(1);
        i_clr = 2'b00;
        tests_run++;
        if ({o_counter[7:0], o_ovf} !== {8'd0, 2'b00}) begin
            tests_failed++; $display("FAIL sat_clear: got %h want %h", {o_counter[7:0], o_ovf}, {8'd0, 2'b00});
        end
    endtask

    task automatic test_snapshot();
        apply_reset();
        i_div = 21'd1; i_evt = 2'b11; i_en = 2'b01;
        step(25);
        i_en = 2'b11;
        step(12);
        i_snap = 1'b1; i_clr = 2'b10;
        step(1);
        i_snap = 1'b0; i_clr = 2'b00;
        tests_run++;
        if ({o_snap, o_snap_vld} !== {8'd12, 8'd37, 1'b1}) begin
            tests_failed++; $display("FAIL snap_coherent: got %h want %h", {o_snap, o_snap_vld}, {8'd12, 8'd37, 1'b1});
        end
        tests_run++;
        if (o_counter !== {8'd0, 8'd38}) begin
            tests_failed++; $display("FAIL snap_clr_counter: got %h want %h", o_counter, {8'd0, 8'd38});
        end
        step(1);
        tests_run++;
        if ({o_snap, o_snap_vld} !== {8'd12, 8'd37, 1'b0}) begin
            tests_failed++; $display("FAIL snap_hold: got %h want %h", {o_snap, o_snap_vld}, {8'd12, 8'd37, 1'b0});
        end
        i_snap = 1'b1;                 // counters now {1,39}
        step(1);
        tests_run++;
        if ({o_snap, o_snap_vld} !== {8'd1, 8'd39, 1'b1}) begin
            tests_failed++; $display("FAIL snap_b2b_first: got %h want %h", {o_snap, o_snap_vld}, {8'd1, 8'd39, 1'b1});
        end
        step(1);
        i_snap = 1'b0;
        tests_run++;
        if ({o_snap, o_snap_vld} !== {8'd2, 8'd40, 1'b1}) begin
            tests_failed++; $display("FAIL snap_b2b_second: got %h want %h", {o_snap, o_snap_vld}, {8'd2, 8'd40, 1'b1});
        end
        step(1);
        tests_run++;
        if (o_snap_vld !== 1'b0) begin
            tests_failed++; $display("FAIL snap_vld_drop: got %b want %b", o_snap_vld, 1'b0);
        end
    endtask

    task automatic test_div_change();
        apply_reset();
        i_div = 21'd8; i_en = 2'b01; i_evt = 2'b01;
        step(5);                       // prescaler at 5, no tick yet
        tests_run++;
        if (o_counter[7:0] !== 8'd0) begin
            tests_failed++; $display("FAIL divchg_pre: got %0d want %0d", o_counter[7:0], 0);
        end
        i_div = 21'd3;
        step(1);
        tests_run++;
        if (o_counter[7:0] !== 8'd1) begin
            tests_failed++; $display("FAIL divchg_immediate: got %0d want %0d", o_counter[7:0], 1);
        end
        step(2);
        tests_run++;
        if (o_counter[7:0] !== 8'd1) begin
            tests_failed++; $display("FAIL divchg_gap: got %0d want %0d", o_counter[7:0], 1);
        end
        step(1);
        tests_run++;
        if (o_counter[7:0] !== 8'd2) begin
            tests_failed++; $display("FAIL divchg_period: got %0d want %0d", o_counter[7:0], 2);
        end
        step(6);
        tests_run++;
        if (o_counter[7:0] !== 8'd4) begin
            tests_failed++; $display("FAIL divchg_steady: got %0d want %0d", o_counter[7:0], 4);
        end
    endtask

    initial begin
        i_reg_rstn = 1'b1;
        i_en = '0; i_evt = '0; i_div = '0; i_sat_mode = 1'b0;
        i_clr = '0; i_snap = 1'b0;
        test_reset();
        test_divide();
        test_gating();
        test_wrap_sat();
        test_snapshot();
        test_div_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
